// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   if_state_e  - fetch FSM state (INIT, ISSUE, WAIT, DROP)
//   if_entry_t  - instruction queue entry {pc, inst}
//   IF_ALIGN_MASK / IF_PC_STEP - word alignment mask and sequential PC step
//   if_align()  - clears the byte-offset bits of an address
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

    localparam logic [31:0] IF_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] IF_PC_STEP    = 32'd4;

    function automatic logic [31:0] if_align(input logic [31:0] addr);
        return addr & IF_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous instruction queue with flush.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   flush_i       - empty the queue; overrides push and pop in the same cycle
//   push_i        - write push_data_i at the tail (caller guarantees not full)
//   pop_i         - drop the head entry (ignored when empty)
//   count_o       - current occupancy
//   valid_o       - registered "queue not empty"
//   head_o        - head entry, forced to zero when the queue is empty
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  if_entry_t              push_data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   valid_o,
    output if_entry_t              head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q;
    logic              pop_s;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        pop_s = pop_i & valid_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = pop_s  ? head_q + AW'(1) : head_q;
            tail_d  = push_i ? tail_q + AW'(1) : tail_q;
            count_d = count_q + CW'(push_i) - CW'(pop_s);
        end
    end

    // Pointer, occupancy and valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    // Entry storage; a flushed push is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    // Head view: zeroed while empty so decode never sees stale data.
    always_comb begin
        if (valid_q) begin
            head_o = mem_q[head_q];
        end else begin
            head_o = '0;
        end
    end

    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit (requesting side of the instruction memory port).
// Keeps the fetch PC, issues one word read at a time, queues returned
// instructions with their PCs for decode, and handles branch redirects.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   o_ren, o_addr            - registered read strobe / word address (held until i_rvd)
//   i_rvd, i_inst            - response strobe / data
//   i_redir, i_redir_pc      - redirect strobe / target (low two bits ignored)
//   o_valid, o_inst, o_pc    - queue head to decode
//   i_ready                  - decode accepts head
// Optional feature macro IFETCH_PERF_EN adds o_fetch_cnt (pops) and
// o_drop_cnt (discarded responses).
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_ren,
    output logic [31:0] o_addr,
    input  logic        i_rvd,
    input  logic [31:0] i_inst,
    input  logic        i_redir,
    input  logic [31:0] i_redir_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_drop_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_state_e     state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          ren_q, ren_d;

    logic          flush_s, push_s, pop_s, rvd_live_s, free_s, issue_s;
    logic [CW-1:0] occ_s, occ_next_s;
    if_entry_t     push_data_s, head_s;
    logic          valid_s;

    // Event decode. o_ren is registered, so the issue decision is taken one
    // cycle early against next-cycle occupancy; this lets a response or a pop
    // free a slot and the next request leave on the very next cycle.
    always_comb begin
        flush_s    = i_redir & (state_q != ST_INIT);
        rvd_live_s = i_rvd & ((state_q == ST_WAIT) | (state_q == ST_DROP));
        push_s     = i_rvd & (state_q == ST_WAIT) & ~i_redir;
        pop_s      = valid_s & i_ready & ~flush_s;
        free_s     = (state_q == ST_ISSUE) | rvd_live_s;
        if (flush_s) begin
            occ_next_s = '0;
        end else begin
            occ_next_s = occ_s + CW'(push_s) - CW'(pop_s);
        end
        issue_s          = free_s & (occ_next_s < CW'(DEPTH));
        push_data_s.pc   = pc_q;
        push_data_s.inst = i_inst;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = issue_s ? ST_WAIT : ST_ISSUE;
            end
            ST_WAIT: begin
                if (i_rvd) begin
                    state_d = issue_s ? ST_WAIT : ST_ISSUE;
                end else if (i_redir) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (i_rvd) begin
                    state_d = issue_s ? ST_WAIT : ST_ISSUE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM outputs: PC update and the next request strobe/address.
    // pc_q tracks the outstanding request address while in WAIT.
    always_comb begin
        if (i_redir) begin
            pc_d = if_align(i_redir_pc);
        end else if (push_s) begin
            pc_d = pc_q + IF_PC_STEP;
        end else begin
            pc_d = pc_q;
        end
        ren_d = issue_s;
        if (issue_s) begin
            addr_d = pc_d;
        end else begin
            addr_d = addr_q;
        end
    end

    // PC and memory-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
            ren_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            ren_q  <= ren_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_s),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .count_o     (occ_s),
        .valid_o     (valid_s),
        .head_o      (head_s)
    );

    assign o_ren   = ren_q;
    assign o_addr  = addr_q;
    assign o_valid = valid_s;
    assign o_inst  = head_s.inst;
    assign o_pc    = head_s.pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;
    logic        drop_s;

    // A live response that is not pushed was discarded (stale or redirected).
    assign drop_s = rvd_live_s & ~push_s;

    // Performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, pop_s};
            drop_cnt_q  <= drop_cnt_q + {31'd0, drop_s};
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch (RESET_PC=0, DEPTH=2).
// Memory model: 5-cycle delay (o_ren at t, i_rvd at t+4), word k = 0x1000_0000+k.
// Cycle 0 is the first cycle with rst low.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic        o_ren;
    logic [31:0] o_addr;
    logic        i_rvd;
    logic [31:0] i_inst;
    logic        i_redir;
    logic [31:0] i_redir_pc;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;
`ifdef IFETCH_PERF_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_drop_cnt;
`endif

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          pops;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    ifetch #(
        .RESET_PC (32'h0),
        .DEPTH    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .o_ren      (o_ren),
        .o_addr     (o_addr),
        .i_rvd      (i_rvd),
        .i_inst     (i_inst),
        .i_redir    (i_redir),
        .i_redir_pc (i_redir_pc),
        .o_valid    (o_valid),
        .o_inst     (o_inst),
        .o_pc       (o_pc),
        .i_ready    (i_ready)
`ifdef IFETCH_PERF_EN
        ,
        .o_fetch_cnt (o_fetch_cnt),
        .o_drop_cnt  (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    // Advance one cycle: count the pop of the ending cycle, then run the memory model.
    task automatic tick();
        if (rst) begin
            pops = 0;
        end else if (o_valid && i_ready && !i_redir) begin
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        i_rvd  = 1'b0;
        i_inst = 32'h0;
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    i_rvd    = 1'b1;
                    i_inst   = 32'h1000_0000 + {2'b00, mem_addr[31:2]};
                    mem_busy = 1'b0;
                end
            end
            if (o_ren) begin
                mem_addr = o_addr;
                mem_busy = 1'b1;
                mem_cnt  = 4;
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ren"},   {31'd0, o_ren},   32'd0);
        check_eq({tag, "_addr"},  o_addr,           32'h0);
        check_eq({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check_eq({tag, "_inst"},  o_inst,           32'h0);
        check_eq({tag, "_pc"},    o_pc,             32'h0);
    endtask

    initial begin
        clk = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; pops = 0;
        rst = 1'b1; i_ready = 1'b1; i_redir = 1'b0; i_redir_pc = 32'h0;
        i_rvd = 1'b0; i_inst = 32'h0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;

        // Streaming with i_ready=1.
        check_reset_outputs("rst0");
        for (int c = 0; c <= 13; c++) begin
            run_to(c);
            check_eq("s1_ren", {31'd0, o_ren}, (c == 2 || c == 7 || c == 12) ? 32'd1 : 32'd0);
            if (c == 2)  check_eq("s1_addr2", o_addr, 32'h0);
            if (c == 7)  check_eq("s1_addr7", o_addr, 32'h4);
            if (c == 12) check_eq("s1_addr12", o_addr, 32'h8);
            if (c == 7) begin
                check_eq("s1_valid7", {31'd0, o_valid}, 32'd1);
                check_eq("s1_pc7", o_pc, 32'h0);
                check_eq("s1_inst7", o_inst, 32'h1000_0000);
            end
        end

        // Redirect to 0x40 two cycles after the request at 0x8.
        run_to(14);
        i_redir = 1'b1; i_redir_pc = 32'h40;
        run_to(15);
        i_redir = 1'b0;
        for (int c = 15; c <= 22; c++) begin
            run_to(c);
            check_eq("rd_ren", {31'd0, o_ren}, (c == 17 || c == 22) ? 32'd1 : 32'd0);
            if (c < 22) check_eq("rd_valid_lo", {31'd0, o_valid}, 32'd0);
        end
        run_to(17);
        run_to(22);
        check_eq("rd_addr22", o_addr, 32'h44);
        check_eq("rd_valid22", {31'd0, o_valid}, 32'd1);
        check_eq("rd_pc22", o_pc, 32'h40);
        check_eq("rd_inst22", o_inst, 32'h1000_0010);
        run_to(23);
`ifdef IFETCH_PERF_EN
        check_eq("perf_drop1", o_drop_cnt, 32'd1);
        check_eq("perf_fetch1", o_fetch_cnt, pops);
`endif

        // Redirect in the same cycle as the response, target 0x13.
        run_to(26);
        i_redir = 1'b1; i_redir_pc = 32'h13;
        run_to(27);
        i_redir = 1'b0;
        check_eq("rr_valid27", {31'd0, o_valid}, 32'd0);
        check_eq("rr_ren27", {31'd0, o_ren}, 32'd1);
        check_eq("rr_addr27", o_addr, 32'h10);
        run_to(28);
        check_eq("rr_valid28", {31'd0, o_valid}, 32'd0);
`ifdef IFETCH_PERF_EN
        check_eq("perf_drop2", o_drop_cnt, 32'd2);
`endif
        run_to(32);
        check_eq("rr_valid32", {31'd0, o_valid}, 32'd1);
        check_eq("rr_pc32", o_pc, 32'h10);
        check_eq("rr_inst32", o_inst, 32'h1000_0004);
        check_eq("rr_ren32", {31'd0, o_ren}, 32'd1);
        check_eq("rr_addr32", o_addr, 32'h14);
        i_ready = 1'b0;

        // Reset while a request is outstanding.
        run_to(34);
        check_eq("mr_valid34", {31'd0, o_valid}, 32'd1);
        rst = 1'b1;
        run_to(35);
        check_reset_outputs("mr35");
        run_to(36);
        rst = 1'b0;
        cyc = 0;

        // Back-pressure with i_ready=0 after a fresh reset.
        check_reset_outputs("rst1");
`ifdef IFETCH_PERF_EN
        check_eq("perf_fetch_rst", o_fetch_cnt, 32'd0);
        check_eq("perf_drop_rst", o_drop_cnt, 32'd0);
`endif
        for (int c = 0; c <= 20; c++) begin
            run_to(c);
            check_eq("bp_ren", {31'd0, o_ren}, (c == 2 || c == 7) ? 32'd1 : 32'd0);
            if (c == 2) check_eq("bp_addr2", o_addr, 32'h0);
        end
        check_eq("bp_valid20", {31'd0, o_valid}, 32'd1);
        check_eq("bp_pc20", o_pc, 32'h0);
        check_eq("bp_inst20", o_inst, 32'h1000_0000);
        i_ready = 1'b1;
        run_to(21);
        check_eq("bp_ren21", {31'd0, o_ren}, 32'd1);
        check_eq("bp_addr21", o_addr, 32'h8);
        check_eq("bp_pc21", o_pc, 32'h4);
        check_eq("bp_inst21", o_inst, 32'h1000_0001);
        run_to(22);
        check_eq("bp_valid22", {31'd0, o_valid}, 32'd0);
        check_eq("bp_ren22", {31'd0, o_ren}, 32'd0);
        run_to(26);
        check_eq("bp_valid26", {31'd0, o_valid}, 32'd1);
        check_eq("bp_pc26", o_pc, 32'h8);
        check_eq("bp_inst26", o_inst, 32'h1000_0002);
        run_to(27);
`ifdef IFETCH_PERF_EN
        check_eq("perf_fetch2", o_fetch_cnt, pops);
        check_eq("perf_drop3", o_drop_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the requesting side of the core's instruction memory port. It keeps the fetch PC and issues one word read at a time on the ren/addr/rvd port. It buffers returned instructions with their PCs in a small queue for decode over a valid/ready handshake. It handles branch redirects by flushing the queue and discarding any response already in flight.

## Interface
- `RESET_PC`, default 32'h0: fetch address after reset. Bits [1:0] must be 0.
- `DEPTH`, default 2: instruction queue entries, power of two, 2..8.
- `clk` input, 1: clock.
- `rst` input, 1: reset, synchronous, active-high.
- `o_ren` input-side request, output, 1: read request strobe. One-cycle pulse per request.
- `o_addr` output, 32: byte address of the request. Bits [1:0] are always 0. Held stable until `i_rvd`.
- `i_rvd` input, 1: response valid. One-cycle pulse per request.
- `i_inst` input, 32: response data. Valid only when `i_rvd` is high.
- `i_redir` input, 1: redirect strobe from execute.
- `i_redir_pc` input, 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `o_valid` output, 1: queue head is valid.
- `o_inst` output, 32: queue head instruction.
- `o_pc` output, 32: queue head PC.
- `i_ready` input, 1: decode accepts the head; a pop occurs on `o_valid & i_ready`.

## Operation
- Memory port contract:
  - The memory accepts `o_ren` only while idle.
  - It is idle from the second cycle after reset release, and again from the cycle after each `i_rvd`.
  - At most one request is outstanding at a time.
- FSM states:
  - INIT: first cycle after reset; `o_ren` stays 0. Go to ISSUE.
  - ISSUE: if credit > 0, assert `o_ren` for this cycle with `o_addr` = PC, then go to WAIT. Otherwise stay.
  - WAIT: on `i_rvd`, push {PC, `i_inst`}, set PC = PC+4 (wraps modulo 2^32), go to ISSUE.
  - DROP: a request is in flight but stale. On `i_rvd`, discard the data and go to ISSUE.
- Credit = DEPTH − occupancy − (request outstanding ? 1 : 0). A push therefore never meets a full queue.
- `i_redir` in any state except INIT:
  - Flush the queue (occupancy becomes 0; a pop in the same cycle is ignored).
  - PC = `i_redir_pc` & ~3.
  - From WAIT, go to DROP; from DROP, stay in DROP; from ISSUE, stay in ISSUE. The issue at the new PC happens next cycle, and the issue in the redirect cycle itself is suppressed.
- `i_redir` in the same cycle as `i_rvd`: the response is discarded and the state goes to ISSUE.
- `i_redir` during INIT: PC is updated and the transition to ISSUE is unchanged.
- Simultaneous push and pop: occupancy is unchanged; head/tail pointers wrap modulo DEPTH.
- `rst` in any state, including mid-request:
  - All state returns to INIT and the queue is emptied.
  - No response from before the reset is consumed, because the memory also resets.

## Timing
- Reset values:
  - `o_ren`=0, `o_addr`=RESET_PC, `o_valid`=0.
  - `o_inst`=0 and `o_pc`=0 when the queue is empty; they show the head entry otherwise.
- All outputs are registered, except `o_inst`/`o_pc`, which are a mux from the queue registers.
- `i_rvd` at cycle t gives `o_valid`=1 at t+1. The next `o_ren` is also at t+1 if credit allows.
- Throughput with an N-cycle memory (`o_ren` at t, `i_rvd` at t+N−1): one instruction per N cycles.
- Redirect at cycle t with nothing in flight: `o_ren` at t+1 with the new address.

## Configuration
- `IFETCH_PERF_EN` defined:
  - Adds outputs `o_fetch_cnt[31:0]`, which counts pops.
  - Adds `o_drop_cnt[31:0]`, which counts discarded responses.
  - Both counters are cleared by `rst` and wrap at 2^32.
- Not defined: these ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- `ifetch_pkg` contains:
  - The state enum (INIT, ISSUE, WAIT, DROP).
  - The queue entry type {pc[31:0], inst[31:0]}.
  - Constant `IF_ALIGN_MASK` = 32'hFFFF_FFFC.
- Sub-module `ifetch_fifo`: DEPTH-entry synchronous FIFO with flush, push, pop, occupancy, and head outputs.
- `ifetch` holds the FSM, PC, credit logic, and perf counters.

## Test plan
The bench memory model has a 5-cycle delay and word k = 0x1000_0000+k.
- Reset release with `i_ready`=1 and RESET_PC=0:
  - `o_ren` pulses at cycles 2, 7, 12 with `o_addr` 0, 4, 8.
  - `o_valid` carries (pc 0, inst 0x1000_0000) at cycle 7.
- `i_ready`=0 with DEPTH=2:
  - Exactly two requests are issued, then `o_ren` stays 0 with occupancy 2.
  - Raising `i_ready` pops PC 0 then PC 4; a new `o_ren` is issued the cycle after the first pop.
- Redirect to 0x40 two cycles after `o_ren` at 0x8:
  - The 0x8 response is discarded.
  - The next `o_ren` has `o_addr`=0x40, the cycle after that `i_rvd`.
  - The next `o_pc` is 0x40 with inst 0x1000_0010.
- `i_redir` in the same cycle as `i_rvd`, target 0x13:
  - The data is dropped and `o_valid` stays 0.
  - The next request has address 0x10.
- `rst` asserted mid-WAIT:
  - `o_ren`=0 and `o_valid`=0 on the following cycle.
  - After release, there is one INIT cycle, then a request at RESET_PC.
- With `IFETCH_PERF_EN`: after the redirect scenario, `o_drop_cnt`=1 and `o_fetch_cnt` equals the number of pops.
